// File: rtl/dmem_access_stage.sv
// Memory-access stage controller: M-stage request -> valid/ready data-cache handshake, with pipeline stall.
// Optional 1-entry posted-write buffer enabled by defining DMEM_POST_WRITE_EN.
module dmem_access_stage #(
   parameter int unsigned WAIT_MAX = 255,
   parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  MaskM,
   output logic        StallM,
   output logic [31:0] ReadDataM,
   output logic        dc_req_valid,
   input  logic        dc_req_ready,
   output logic        dc_req_we,
   output logic [31:0] dc_req_addr,
   output logic [31:0] dc_req_wdata,
   output logic [3:0]  dc_req_mask,
   input  logic        dc_resp_valid,
   input  logic [31:0] dc_resp_data,
   output logic        mem_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int unsigned      WW    = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WW-1:0]    W_MAX = WW'(WAIT_MAX);

   logic [1:0]    r_state;
   logic [WW-1:0] r_wdog;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_mask;
   logic [31:0]   r_rdata;
   logic          r_err;
   logic          r_posted;

   logic          w_start;
   logic          w_busy;
   logic [WW-1:0] w_wdog_nxt;
   logic          w_wdog_hit;
   logic [1:0]    w_wr_next;

   assign w_start    = MemReqM && !(MemWriteM && (MaskM == 4'b0000));
   assign w_busy     = (r_state == S_REQ) || (r_state == S_WAIT);
   assign w_wdog_nxt = (r_wdog == W_MAX) ? W_MAX : r_wdog + 1'b1;
   assign w_wdog_hit = w_busy && (w_wdog_nxt == W_MAX);

`ifdef DMEM_POST_WRITE_EN
   // A posted store has already retired, so its drain skips DONE.
   assign w_wr_next = r_posted ? S_IDLE : S_DONE;

   always_comb begin
      StallM = 1'b0;
      case (r_state)
         S_IDLE:         StallM = w_start && !MemWriteM;
         S_REQ, S_WAIT:  StallM = r_posted ? w_start : 1'b1;
         default:        StallM = 1'b0;
      endcase
   end
`else
   assign w_wr_next = S_DONE;

   always_comb begin
      StallM = 1'b0;
      case (r_state)
         S_IDLE:         StallM = w_start;
         S_REQ, S_WAIT:  StallM = 1'b1;
         default:        StallM = 1'b0;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_wdog   <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_mask   <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
         r_posted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_wdog <= '0;
               if (w_start) begin
                  r_addr  <= ALUOutM & 32'hFFFF_FFFC;
                  r_we    <= MemWriteM;
                  r_wdata <= WriteDataM;
                  r_mask  <= MemWriteM ? MaskM : 4'b1111;
                  r_state <= S_REQ;
`ifdef DMEM_POST_WRITE_EN
                  r_posted <= MemWriteM;
`endif
               end
            end
            S_REQ: begin
               r_wdog <= w_wdog_nxt;
               if (dc_req_ready) begin
                  r_state  <= r_we ? w_wr_next : S_WAIT;
                  r_posted <= 1'b0;
               end else if (w_wdog_hit) begin
                  r_err    <= 1'b1;
                  if (!r_we) r_rdata <= BAD_DATA;
                  r_state  <= r_we ? w_wr_next : S_DONE;
                  r_posted <= 1'b0;
               end
            end
            S_WAIT: begin
               r_wdog <= w_wdog_nxt;
               if (dc_resp_valid) begin
                  r_rdata <= dc_resp_data;
                  r_state <= S_DONE;
               end else if (w_wdog_hit) begin
                  r_err   <= 1'b1;
                  r_rdata <= BAD_DATA;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dc_req_valid = (r_state == S_REQ);
   assign dc_req_we    = r_we;
   assign dc_req_addr  = r_addr;
   assign dc_req_wdata = r_wdata;
   assign dc_req_mask  = r_mask;
   assign ReadDataM    = r_rdata;
   assign mem_err      = r_err;

endmodule

// File: tb/tb_dmem_access_stage.sv
// Self-checking bench for dmem_access_stage: table of M-stage accesses against a cache model,
// scoreboarded per instruction, plus reset and (when DMEM_POST_WRITE_EN is defined) posted-write sequences.
module tb_dmem_access_stage;

   localparam int TB_WMAX = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReqM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [3:0]  MaskM;
   logic        StallM;
   logic [31:0] ReadDataM;
   logic        dc_req_valid, dc_req_ready, dc_req_we;
   logic [31:0] dc_req_addr, dc_req_wdata;
   logic [3:0]  dc_req_mask;
   logic        dc_resp_valid;
   logic [31:0] dc_resp_data;
   logic        mem_err;

   always #5 clk = ~clk;

   dmem_access_stage #(.WAIT_MAX(TB_WMAX), .BAD_DATA(32'hDEADBEEF)) u_dut (
      .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .MaskM(MaskM), .StallM(StallM),
      .ReadDataM(ReadDataM), .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
      .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
      .dc_req_mask(dc_req_mask), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_err(mem_err)
   );

   // rdly/respdly < 0 means the cache never answers that phase
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      int          rdly;
      int          respdly;
      logic [31:0] rdata;
      int          exp_stall;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_hs;
   } vec_t;

   vec_t vecs[10];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   stall = 0, hs = 0, vcyc = 0, wcnt = 0, exp_vcyc;
      bit   accepted = 0, fields_ok = 1, retired = 0;
      vec_t e;
      logic [31:0] a;
      a = v.addr;
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = v.we; ALUOutM = v.addr; WriteDataM = v.wdata; MaskM = v.mask;
      sb.push_back(v);
      for (int c = 0; c < 40 && !retired; c++) begin
         #1;
         dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
         if (!StallM) begin
            retired = 1;
            e = sb.pop_front();
            if (e.we && e.mask == 4'b0000) exp_vcyc = 0;
            else if (e.rdly >= 0 && e.rdly < TB_WMAX) exp_vcyc = e.rdly + 1;
            else exp_vcyc = TB_WMAX;
            check($sformatf("v%0d stall_cycles", idx), stall, e.exp_stall);
            check($sformatf("v%0d handshakes", idx), hs, e.exp_hs);
            check($sformatf("v%0d valid_cycles", idx), vcyc, exp_vcyc);
            check($sformatf("v%0d req_fields", idx), {31'd0, fields_ok}, 32'd1);
            check($sformatf("v%0d ReadDataM", idx), ReadDataM, e.exp_rd);
            check($sformatf("v%0d mem_err", idx), {31'd0, mem_err}, {31'd0, e.exp_err});
         end else begin
            stall++;
            if (accepted && v.respdly >= 0 && wcnt == v.respdly) begin
               dc_resp_valid = 1'b1; dc_resp_data = v.rdata;
            end
            if (accepted) wcnt++;
            if (dc_req_valid) begin
               if (dc_req_addr !== {a[31:2], 2'b00} || dc_req_we !== v.we ||
                   dc_req_mask !== (v.we ? v.mask : 4'hF) || (v.we && dc_req_wdata !== v.wdata))
                  fields_ok = 0;
               if (v.rdly >= 0 && vcyc == v.rdly) begin
                  dc_req_ready = 1'b1; hs++;
                  if (!v.we) accepted = 1;
               end
               vcyc++;
            end
            @(negedge clk);
         end
      end
      if (!retired) begin
         n_checks++; n_errors++;
         $display("FAIL v%0d retire_timeout: got no retire expected retire within 40 cycles", idx);
         void'(sb.pop_front());
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0000_100C, 32'h0, 4'h0, 0, 0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 1'b0, 1};
      vecs[1] = '{1'b1, 32'h0000_2002, 32'h00AB0000, 4'b0100, 4, -1, 32'h0, 6, 32'hCAFEF00D, 1'b0, 1};
      vecs[2] = '{1'b1, 32'h0000_2400, 32'h12121212, 4'b0000, 0, -1, 32'h0, 0, 32'hCAFEF00D, 1'b0, 0};
      vecs[3] = '{1'b0, 32'h0000_3001, 32'h0, 4'hF, 2, 3, 32'h12345678, 8, 32'h12345678, 1'b0, 1};
      vecs[4] = '{1'b1, 32'h0000_0040, 32'hA5A5A5A5, 4'hF, 0, -1, 32'h0, 2, 32'h12345678, 1'b0, 1};
      vecs[5] = '{1'b0, 32'h0000_5000, 32'h0, 4'h0, -1, -1, 32'h0, 9, 32'hDEADBEEF, 1'b1, 0};
      vecs[6] = '{1'b0, 32'h0000_5004, 32'h0, 4'h0, 1, -1, 32'h0, 9, 32'hDEADBEEF, 1'b1, 1};
      vecs[7] = '{1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 32'h0BADF00D, 3, 32'h0BADF00D, 1'b1, 1};
      vecs[8] = '{1'b1, 32'h0000_600A, 32'h0000FF00, 4'b0010, -1, -1, 32'h0, 9, 32'h0BADF00D, 1'b1, 0};
      vecs[9] = '{1'b0, 32'h0000_7FFF, 32'h0, 4'h0, 3, 1, 32'h5A5A0F0F, 7, 32'h5A5A0F0F, 1'b1, 1};

      reset = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0; MaskM = '0;
      dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = 32'h11111111;

      // Reset with a stale response pulse, then one more stale pulse in IDLE
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      dc_resp_valid = 1'b0;
      @(negedge clk); #1;
      check("rst StallM", {31'd0, StallM}, 32'd0);
      check("rst dc_req_valid", {31'd0, dc_req_valid}, 32'd0);
      check("rst dc_req_we", {31'd0, dc_req_we}, 32'd0);
      check("rst dc_req_addr", dc_req_addr, 32'd0);
      check("rst dc_req_wdata", dc_req_wdata, 32'd0);
      check("rst dc_req_mask", {28'd0, dc_req_mask}, 32'd0);
      check("rst ReadDataM", ReadDataM, 32'd0);
      check("rst mem_err", {31'd0, mem_err}, 32'd0);

`ifndef DMEM_POST_WRITE_EN
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
`else
      begin
         int step = 0, wr_at = -1, rd_at = -1, stall = 0;
         bit done = 0, rd_acc = 0;
         @(negedge clk);
         MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h600; WriteDataM = 32'h55; MaskM = 4'hF;
         #1 check("pw store_stall", {31'd0, StallM}, 32'd0);
         @(negedge clk);
         MemWriteM = 1'b0; ALUOutM = 32'h604; MaskM = 4'h0;
         for (int c = 0; c < 30 && !done; c++) begin
            #1;
            dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
            if (!StallM) done = 1;
            else begin
               stall++;
               if (rd_acc) begin dc_resp_valid = 1'b1; dc_resp_data = 32'h99; rd_acc = 0; end
               if (dc_req_valid) begin
                  if (c >= 1) begin
                     dc_req_ready = 1'b1;
                     if (dc_req_we) wr_at = step; else begin rd_at = step; rd_acc = 1; end
                     step++;
                  end
               end
               @(negedge clk);
            end
         end
         check("pw load_retired", {31'd0, done}, 32'd1);
         check("pw write_first", {31'd0, (wr_at == 0 && rd_at == 1)}, 32'd1);
         check("pw load_stall", stall, 32'd5);
         check("pw ReadDataM", ReadDataM, 32'h99);
      end
`endif

      // Reset in the middle of a load: request abandoned, later response ignored
      @(negedge clk);
      MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'h500; MaskM = 4'h0;
      dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
      @(negedge clk); #1;
      check("midrst valid_before", {31'd0, dc_req_valid}, 32'd1);
      reset = 1'b0; MemReqM = 1'b0;
      @(negedge clk); #1;
      check("midrst valid_after", {31'd0, dc_req_valid}, 32'd0);
      check("midrst mem_err", {31'd0, mem_err}, 32'd0);
      reset = 1'b1; dc_resp_valid = 1'b1; dc_resp_data = 32'h77777777;
      @(negedge clk); #1;
      dc_resp_valid = 1'b0;
      @(negedge clk); #1;
      check("midrst stale_resp", ReadDataM, 32'd0);
      check("midrst StallM", {31'd0, StallM}, 32'd0);
      run_vec('{1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 32'h600DD00D, 3, 32'h600DD00D, 1'b0, 1}, 10);

      @(negedge clk);
      MemReqM = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
